df_peak_hold: RTL

Downstream of the filter top: takes the 8-bit filtered sample stream and produces a windowed peak level with hold-then-decay ballistics. It feeds the 7-segment/level display logic. The output moves only at window boundaries, so the display stays stable while the filter output swings every clock.

---
 rtl/df_peak_hold_if.sv | 20 ++
 rtl/df_peak_hold.sv | 99 +++++++++
 2 files changed

// File: rtl/df_peak_hold_if.sv
// rtl/df_peak_hold_if.sv - sample/peak bus for df_peak_hold
interface df_peak_hold_if;
  logic       ena;
  logic       clr;
  logic [7:0] sample_in;
  logic       sample_vld;
  logic [7:0] peak_out;
  logic       peak_vld;
  logic       hold_active;

  modport master (
    output ena, clr, sample_in, sample_vld,
    input  peak_out, peak_vld, hold_active
  );

  modport slave (
    input  ena, clr, sample_in, sample_vld,
    output peak_out, peak_vld, hold_active
  );
endinterface

// File: rtl/df_peak_hold.sv
// rtl/df_peak_hold.sv - windowed peak level with hold-then-decay ballistics
// Optional DF_PEAK_RECTIFY_EN: rectify offset-binary samples around 0x80.
module df_peak_hold #(
  parameter int WINDOW       = 16,
  parameter int HOLD_WINDOWS = 2,
  parameter int DECAY_SHIFT  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  df_peak_hold_if.slave bus
);
  localparam int WCW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int HCW = (HOLD_WINDOWS > 0) ? $clog2(HOLD_WINDOWS + 1) : 1;
  localparam logic [WCW-1:0] LAST  = WCW'(WINDOW - 1);
  localparam logic [HCW-1:0] HLOAD = HCW'(HOLD_WINDOWS);

  typedef enum logic {ST_DECAY = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t         r_state, w_state_nxt;
  logic [WCW-1:0] r_wcnt;
  logic [7:0]     r_wmax, r_peak;
  logic [HCW-1:0] r_hcnt;
  logic           r_vld;

  logic [7:0]     w_s, w_m, w_shift, w_dec, w_sub, w_peak_nxt;
  logic [HCW-1:0] w_hcnt_nxt;
  logic           w_clr, w_acc, w_close;

`ifdef DF_PEAK_RECTIFY_EN
  logic [8:0] w_neg;
  // Below midscale the doubled distance can reach 256, so it saturates.
  assign w_neg = (9'd128 - {1'b0, bus.sample_in}) << 1;
  assign w_s   = bus.sample_in[7] ? {bus.sample_in[6:0], 1'b0}
                                  : (w_neg[8] ? 8'hFF : w_neg[7:0]);
`else
  assign w_s = bus.sample_in;
`endif

  assign w_clr   = bus.ena & bus.clr;
  assign w_acc   = bus.ena & bus.sample_vld & ~bus.clr;
  assign w_close = w_acc & (r_wcnt == LAST);
  assign w_m     = ((r_wcnt == '0) || (w_s > r_wmax)) ? w_s : r_wmax;

  assign w_shift = r_peak >> DECAY_SHIFT;
  assign w_dec   = (w_shift == 8'd0) ? 8'd1 : w_shift;
  assign w_sub   = r_peak - w_dec;

  always_comb begin
    w_state_nxt = r_state;
    w_peak_nxt  = r_peak;
    w_hcnt_nxt  = r_hcnt;
    if (w_clr) begin
      w_state_nxt = ST_DECAY;
      w_peak_nxt  = 8'd0;
      w_hcnt_nxt  = '0;
    end else if (w_close) begin
      if (w_m >= r_peak) begin
        w_peak_nxt  = w_m;
        w_hcnt_nxt  = HLOAD;
        w_state_nxt = (HOLD_WINDOWS == 0) ? ST_DECAY : ST_HOLD;
      end else if (r_state == ST_HOLD) begin
        w_hcnt_nxt = r_hcnt - 1'b1;
        if (r_hcnt == HCW'(1)) w_state_nxt = ST_DECAY;
      end else begin
        w_peak_nxt = (w_m > w_sub) ? w_m : w_sub;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_DECAY;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt <= '0;
      r_wmax <= 8'd0;
      r_peak <= 8'd0;
      r_hcnt <= '0;
      r_vld  <= 1'b0;
    end else begin
      r_peak <= w_peak_nxt;
      r_hcnt <= w_hcnt_nxt;
      r_vld  <= w_close;
      if (w_clr) begin
        r_wcnt <= '0;
        r_wmax <= 8'd0;
      end else if (w_acc) begin
        r_wcnt <= w_close ? '0 : r_wcnt + 1'b1;
        r_wmax <= w_m;
      end
    end
  end

  assign bus.peak_out    = r_peak;
  assign bus.peak_vld    = r_vld;
  assign bus.hold_active = (r_state == ST_HOLD);
endmodule
